vec_pack: RTL and testbench

- Collects a stream of signed scalar results, one per accepted cycle, into a packed DIMENSION×WIDTH vector.
- Inverse of the vector serializer that feeds the PE array: element 0 arrives first and lands in bits [WIDTH-1:0].
- Sits at the PE output side; presents the finished vector to the next layer or memory writer with a valid/ready handshake.
- Double-buffered (assembly + output register), so a full-rate input stream is sustained while downstream drains.

---
 rtl/vec_pkg.sv | 13 +
 rtl/vec_pack_sat_narrow.sv | 38 +++
 rtl/vec_pack.sv | 123 ++++++++++++
 tb/tb_vec_pack.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared vector-format constants and types for serializer, PE array and packer.
// No logic: constants, count-width helper and packed vector type only.
// Backpressure: n/a.
package vec_pkg;
    localparam int VEC_DIMENSION = 16;
    localparam int VEC_WIDTH     = 8;

    function automatic int count_width(input int dimension);
        return $clog2(dimension + 1);
    endfunction

    typedef logic [VEC_DIMENSION*VEC_WIDTH-1:0] vec_t;
endpackage

// File: rtl/vec_pack_sat_narrow.sv
// Narrows one IN_WIDTH element to WIDTH: clamp with VEC_PACK_SAT_EN, otherwise truncate.
// Latency: combinational.
// Backpressure: none, pure function of in_data.
module sat_narrow #(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = 8
) (
    input  logic [IN_WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]    out_data,
    output logic                ovf
);
`ifdef VEC_PACK_SAT_EN
    localparam int HI = IN_WIDTH - WIDTH + 1;

    // The value fits iff every bit from the output sign bit upward agrees.
    logic [HI-1:0] hi_bits;
    assign hi_bits = in_data[IN_WIDTH-1:WIDTH-1];
    assign ovf     = (hi_bits != '0) && (hi_bits != '1);

    always_comb begin
        out_data = in_data[WIDTH-1:0];
        if (ovf) begin
            out_data = in_data[IN_WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign out_data = in_data[WIDTH-1:0];
    assign ovf      = 1'b0;

    generate
        if (IN_WIDTH > WIDTH) begin : g_drop
            logic unused_hi;
            assign unused_hi = ^in_data[IN_WIDTH-1:WIDTH];
        end
    endgenerate
`endif
endmodule

// File: rtl/vec_pack.sv
// Packs a scalar stream into DIMENSION x WIDTH vectors (VEC_PACK_SAT_EN selects clamping).
// Latency: 1 cycle from completing element to out_valid.
// Backpressure: one completed vector may wait in assembly; in_ready drops only then.
module vec_pack
    import vec_pkg::*;
#(
    parameter int DIMENSION = VEC_DIMENSION,
    parameter int WIDTH     = VEC_WIDTH,
    parameter int IN_WIDTH  = VEC_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IN_WIDTH-1:0]                  in_data,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [DIMENSION*WIDTH-1:0]           out_vec,
    output logic [count_width(DIMENSION)-1:0]    out_count,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 sat_flag
);
    localparam int CW = count_width(DIMENSION);
    localparam int IW = $clog2(DIMENSION);
    localparam int VW = DIMENSION * WIDTH;

    logic [WIDTH-1:0] elem;
    logic             elem_ovf;

    sat_narrow #(.IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH)) u_narrow (
        .in_data  (in_data),
        .out_data (elem),
        .ovf      (elem_ovf)
    );

    logic [VW-1:0] asm_vec_q, asm_vec_d, out_vec_q, out_vec_d, merged;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] pend_cnt_q, pend_cnt_d, out_count_q, out_count_d, fill_cnt;
    logic          pend_q, pend_d, out_valid_q, out_valid_d, sat_flag_q, sat_flag_d;
    logic          accept, can_xfer, done;

    assign in_ready = rst && !pend_q;
    assign accept   = in_valid && in_ready;
    assign can_xfer = !out_valid_q || out_ready;
    assign done     = (idx_q == IW'(DIMENSION - 1)) || in_last;
    assign fill_cnt = CW'(idx_q) + CW'(1);

    always_comb begin
        merged = asm_vec_q;
        merged[idx_q*WIDTH +: WIDTH] = elem;
    end

    always_comb begin
        asm_vec_d   = asm_vec_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_cnt_d  = pend_cnt_q;
        out_vec_d   = out_vec_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        sat_flag_d  = sat_flag_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (pend_q) begin
            if (can_xfer) begin
                out_vec_d   = asm_vec_q;
                out_count_d = pend_cnt_q;
                out_valid_d = 1'b1;
                asm_vec_d   = '0;
                pend_d      = 1'b0;
            end
        end else if (accept) begin
            sat_flag_d = sat_flag_q | elem_ovf;
            if (done) begin
                idx_d = '0;
                if (can_xfer) begin
                    // Assembly clears so untouched slots of the next vector read zero.
                    out_vec_d   = merged;
                    out_count_d = fill_cnt;
                    out_valid_d = 1'b1;
                    asm_vec_d   = '0;
                end else begin
                    asm_vec_d  = merged;
                    pend_d     = 1'b1;
                    pend_cnt_d = fill_cnt;
                end
            end else begin
                asm_vec_d = merged;
                idx_d     = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            asm_vec_q   <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_cnt_q  <= '0;
            out_vec_q   <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            asm_vec_q   <= asm_vec_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            out_vec_q   <= out_vec_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign out_vec   = out_vec_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_vec_pack.sv
// Directed and randomized checks of vec_pack (DIMENSION=4, WIDTH=8, IN_WIDTH=16)
// against a queue-based reference of completed vectors.
module tb_vec_pack;
    localparam int DIM = 4;
    localparam int W   = 8;
    localparam int IW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_data;
    logic          in_valid, in_last, in_ready;
    logic [31:0]   out_vec;
    logic [2:0]    out_count;
    logic          out_valid, out_ready, sat_flag;

    vec_pack #(.DIMENSION(DIM), .WIDTH(W), .IN_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;

    logic [7:0] cur[$];
    exp_t       exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_out    = 0;
    int         n_done   = 0;
    bit         sat_m    = 0;
`ifdef VEC_PACK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_accept(input int x, input bit last);
        int   y;
        exp_t e;
        y = x;
        if (SAT) begin
            if (y > 127) begin y = 127; sat_m = 1; end
            else if (y < -128) begin y = -128; sat_m = 1; end
        end
        cur.push_back(8'(y));
        if (cur.size() == DIM || last) begin
            e.v = '0;
            foreach (cur[i]) e.v[i*8 +: 8] = cur[i];
            e.c = cur.size();
            exp_q.push_back(e);
            cur.delete();
            n_done++;
        end
    endtask

    // Observe at negedge, commit model state for the coming posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            chk(32'(in_ready), 32'(exp_q.size() < 2), "in_ready");
            chk(32'(out_valid), 32'(exp_q.size() > 0), "out_valid");
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(32'(out_valid), 32'd0, "unexpected_out");
                end else begin
                    e = exp_q.pop_front();
                    chk(out_vec, e.v, "sb_vec");
                    chk(32'(out_count), 32'(e.c), "sb_count");
                    n_out++;
                end
            end
            if (in_valid && in_ready) model_accept(int'($signed(in_data)), in_last);
        end else begin
            chk(32'(in_ready), 32'd0, "in_ready_rst");
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            cur.delete();
            exp_q.delete();
            sat_m = 0;
        end
    endtask

    task automatic send(input int x, input bit last);
        in_valid = 1'b1;
        in_data  = IW'(x);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int base;
        int cyc;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk(32'(in_ready), 32'd1, "rst_in_ready");
        chk(32'(out_valid), 32'd0, "rst_out_valid");
        chk(out_vec, 32'd0, "rst_out_vec");
        chk(32'(out_count), 32'd0, "rst_out_count");
        chk(32'(sat_flag), 32'd0, "rst_sat_flag");

        // Full vector, latency 1, valid for one cycle
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) send(k, 0);
        chk(32'(out_valid), 32'd1, "lat_valid");
        chk(out_vec, 32'h04030201, "lat_vec");
        chk(32'(out_count), 32'd4, "lat_count");
        tick();
        chk(32'(out_valid), 32'd0, "lat_valid_drop");

        // Back-to-back with downstream stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) send(k, 0);
        chk(32'(in_ready), 32'd0, "pend_in_ready");
        tick();
        tick();
        chk(out_vec, 32'h04030201, "stall_hold_vec");
        out_ready = 1'b1;
        tick();
        chk(out_vec, 32'h08070605, "pend_second_vec");
        chk(32'(out_valid), 32'd1, "pend_second_valid");
        chk(32'(in_ready), 32'd1, "pend_ready_back");
        tick();
        chk(32'(out_valid), 32'd0, "pend_drained");

        // Short vector then a full one from slot 0
        send(9, 0);
        send(10, 1);
        chk(out_vec, 32'h00000A09, "short_vec");
        chk(32'(out_count), 32'd2, "short_count");
        for (int k = 1; k <= 4; k++) send(k, 0);
        chk(out_vec, 32'h04030201, "after_short_vec");
        tick();

        // Reset mid-vector
        send(7, 0);
        send(8, 0);
        rst = 1'b0;
        tick();
        chk(32'(out_valid), 32'd0, "mid_rst_valid");
        rst = 1'b1;
        #1;
        chk(32'(out_valid), 32'd0, "post_rst_valid");
        base = n_out;
        for (int k = 1; k <= 4; k++) send(k, 0);
        chk(out_vec, 32'h04030201, "post_rst_vec");
        tick();
        tick();
        chk(32'(n_out - base), 32'd1, "post_rst_count_out");

        // Narrowing of out-of-range values
        send(300, 0);
        send(-200, 1);
        chk(out_vec, SAT ? 32'h0000807F : 32'h0000382C, "narrow_vec");
        chk(32'(out_count), 32'd2, "narrow_count");
        chk(32'(sat_flag), 32'(SAT), "narrow_sat_flag");
        tick();

        // Randomized traffic
        base = n_out;
        cyc  = 0;
        begin
            int done_base;
            done_base = n_done;
            while (n_out < base + 1000 && cyc < 40000) begin
                in_valid  = (n_done < done_base + 1000) && ($urandom_range(0, 9) < 7);
                in_data   = IW'($urandom_range(0, 800)) - IW'(400);
                in_last   = ($urandom_range(0, 4) == 0);
                out_ready = ($urandom_range(0, 9) < 7);
                tick();
                cyc++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk(32'(n_out - base), 32'd1000, "rand_vectors_out");
        chk(32'(exp_q.size()), 32'd0, "rand_no_leftover");
        chk(32'(sat_flag), 32'(sat_m), "rand_sat_flag");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
